mna_stamper: RTL
================

# mna_stamper

Upstream assembly stage for the Jacobi solver. It accepts a stream of component stamps: conductances between nodes, and current injections into nodes. It accumulates them into the nodal matrix A and the right-hand-side vector b, then checks that the diagonal is usable. The results are presented as the solver's A and b inputs with a level `matrix_valid` flag. All values are signed fixed point with W = PRECISION+POINT bits, POINT of them fractional.

## Interface
- `SIZE`, 3: number of non-ground nodes (matrix dimension).
- `PRECISION`, 24: integer bits.
- `POINT`, 12: fractional bits.
- `clk`  in  1: the single clock.
- `I_RSTn`  in  1: reset; asynchronous, active-low.
- `start`  in  1: one-cycle pulse that begins a new assembly.
- `stamp_valid`  in  1: stamp offered.
- `stamp_ready`  out  1: stamp can be accepted. A transfer occurs when valid and ready are both high.
- `stamp_kind`  in  1: 0 = conductance, 1 = current injection.
- `node_a`, `node_b`  in  $clog2(SIZE+1): node indices; index SIZE and above means ground.
- `stamp_value`  in  W signed: conductance g or current i.
- `stamp_last`  in  1: marks the final stamp of the assembly.
- `A`  out  [SIZE][SIZE] x W signed: assembled matrix.
- `b`  out  [SIZE] x W signed: assembled vector.
- `matrix_valid`  out  1: A and b are complete and stable.
- `sat`  out  1: sticky flag; some accumulation saturated.
- `diag_err`  out  1: some diagonal entry A[i][i] is ≤ 0.

## Operation
- States: IDLE, CLEAR, ACCEPT, APPLY_DIAG, APPLY_OFF, CHECK, DONE.
- IDLE: `stamp_ready`=0. On `start` go to CLEAR.
- CLEAR (1 cycle): zero all A and b entries, clear `sat` and `diag_err`, drop `matrix_valid`. Then go to ACCEPT.
- ACCEPT: `stamp_ready`=1. On a transfer, latch kind, nodes, value and last, then go to APPLY_DIAG.
- Conductance stamp, applied in two steps:
  - APPLY_DIAG: A[a][a] += g and A[b][b] += g.
  - APPLY_OFF: A[a][b] −= g and A[b][a] −= g.
- Current stamp: b[a] += i in APPLY_DIAG, b[b] −= i in APPLY_OFF.
- Any term that involves a ground index is skipped.
- If node_a == node_b, the stamp is a no-op but still takes both APPLY cycles.
- After APPLY_OFF: if the latched last bit is clear, return to ACCEPT; if set, go to CHECK.
- CHECK: walk i = 0..SIZE−1, one per cycle. Set `diag_err` if A[i][i] ≤ 0.
- DONE: `matrix_valid`=1. A and b hold until the next `start`.
- Arithmetic: each add or subtract is computed at W+1 bits, then clamped to ±(2^(W−1)−1). Any clamp sets `sat`. No rounding is needed, because all operands share the same POINT.
- `start` in any state other than IDLE aborts the current work and goes to CLEAR on the next cycle. `start` has priority over a simultaneous stamp transfer, and that stamp is dropped.
- `stamp_valid` while `stamp_ready`=0 is ignored. The upstream source must hold the stamp stable until it is accepted.

## Timing
- Reset values: state IDLE, all A and b entries 0, `stamp_ready`=0, `matrix_valid`=0, `sat`=0, `diag_err`=0.
- `start` at cycle N: CLEAR at N+1, `stamp_ready`=1 from N+2.
- Stamp accepted at cycle M:
  - APPLY_DIAG at M+1; its results are visible at M+2.
  - APPLY_OFF at M+2; its results are visible at M+3.
  - `stamp_ready` is high again at M+3.
- Throughput: one stamp per 3 cycles.
- Last stamp accepted at M: CHECK occupies M+3 .. M+3+SIZE−1. `matrix_valid` rises at M+3+SIZE, with `diag_err` already final.
- Reset asserted mid-assembly: immediate return to the reset values. No partial matrix remains visible.

## Structure
- Shared package `mna_pkg`:
  - state enum;
  - stamp-kind constants (COND=0, CURR=1);
  - the saturating add function;
  - W and the ground index SIZE, expressed as derived localparams.
- One natural sub-module: `sat_addsub`, a W-bit signed add/sub with clamp and overflow flag. Instantiate it four times, one per term written per cycle.

## Test plan
- Solver example assembly, W=36, POINT=12. Stamps (ground = 3):
  - g=1 between 0–1;
  - g=1 between 1–2;
  - g=2 between 0–3;
  - g=1 between 1–3;
  - g=1 between 2–3;
  - current 52 into 0–3, with last set.
  - Required result: A = [[3,−1,0],[−1,3,−1],[0,−1,2]] and b = [52,0,0], each <<<12. `matrix_valid` at 3·6+3 = 21 cycles after the first accept, `diag_err`=0, `sat`=0.
- Ground/self cases:
  - g=5 between 2–2: A unchanged.
  - current 4 between 3–3: b unchanged.
  - Both stamps still take 3 cycles each.
- Saturation:
  - Two stamps of g = 2^(W−1)−1 on 0–3: A[0][0] clamps to 2^(W−1)−1 and `sat`=1.
  - `sat` clears on the next `start`.
- Diagonal error: a single stamp g=−1 on 1–3, last set: `diag_err`=1 with `matrix_valid`=1. Nodes 0 and 2 have a 0 diagonal, which also counts as an error.
- Abort and reset:
  - `start` during APPLY_OFF: all entries zero two cycles later and `matrix_valid`=0.
  - `I_RSTn` low mid-CHECK: all outputs return to their reset values at once.
- Backpressure: hold `stamp_valid` high continuously. Exactly one acceptance per 3 cycles; no stamp is applied twice.

Source files
------------

// File: rtl/mna_pkg.sv
// Shared types and helpers for the MNA stamp assembler: FSM states, stamp kinds,
// derived widths and the clamped fixed-point add/subtract.
package mna_pkg;

    localparam int MNA_SIZE      = 3;
    localparam int MNA_PRECISION = 24;
    localparam int MNA_POINT     = 12;
    localparam int MNA_W         = MNA_PRECISION + MNA_POINT;
    localparam int MNA_GND       = MNA_SIZE;

    localparam logic KIND_COND = 1'b0;
    localparam logic KIND_CURR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCEPT,
        ST_APPLY_DIAG,
        ST_APPLY_OFF,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Returns {overflow, result}; result clamped to +/-(2^(W-1)-1).
    function automatic logic [MNA_W:0] sat_add(input logic [MNA_W-1:0] x,
                                              input logic [MNA_W-1:0] y,
                                              input logic             sub);
        logic signed [MNA_W:0] s;
        logic                  pos_ovf;
        logic                  neg_ovf;
        s = sub ? ($signed({x[MNA_W-1], x}) - $signed({y[MNA_W-1], y}))
                : ($signed({x[MNA_W-1], x}) + $signed({y[MNA_W-1], y}));
        pos_ovf = ~s[MNA_W] & s[MNA_W-1];
        neg_ovf = s[MNA_W] & (s[MNA_W-1:0] <= {1'b1, {(MNA_W-1){1'b0}}});
        if (pos_ovf)
            return {1'b1, 1'b0, {(MNA_W-1){1'b1}}};
        else if (neg_ovf)
            return {1'b1, 1'b1, {(MNA_W-2){1'b0}}, 1'b1};
        else
            return {1'b0, s[MNA_W-1:0]};
    endfunction

endpackage

// File: rtl/mna_stamper_sat_addsub.sv
// W-bit signed add/sub evaluated at W+1 bits, clamped symmetrically to
// +/-(2^(W-1)-1); ovf flags any clamp. Purely combinational.
module sat_addsub #(
    parameter int W = 36
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] r,
    output logic         ovf
);
    logic signed [W:0] s;
    logic              pos_ovf;
    logic              neg_ovf;

    always_comb begin
        s = sub ? ($signed({x[W-1], x}) - $signed({y[W-1], y}))
                : ($signed({x[W-1], x}) + $signed({y[W-1], y}));
        pos_ovf = ~s[W] & s[W-1];
        // The most negative W-bit value is also clamped to keep the range symmetric.
        neg_ovf = s[W] & (s[W-1:0] <= {1'b1, {(W-1){1'b0}}});
        ovf     = pos_ovf | neg_ovf;
        if (pos_ovf)
            r = {1'b0, {(W-1){1'b1}}};
        else if (neg_ovf)
            r = {1'b1, {(W-2){1'b0}}, 1'b1};
        else
            r = s[W-1:0];
    end
endmodule

// File: rtl/mna_stamper.sv
// Accumulates conductance/current stamps into nodal matrix A and vector b, then
// checks the diagonal; one stamp per 3 cycles, matrix_valid held until next start.
module mna_stamper
    import mna_pkg::*;
#(
    parameter int SIZE      = MNA_SIZE,
    parameter int PRECISION = MNA_PRECISION,
    parameter int POINT     = MNA_POINT
) (
    input  logic                                                clk,
    input  logic                                                I_RSTn,
    input  logic                                                start,
    input  logic                                                stamp_valid,
    output logic                                                stamp_ready,
    input  logic                                                stamp_kind,
    input  logic [$clog2(SIZE+1)-1:0]                           node_a,
    input  logic [$clog2(SIZE+1)-1:0]                           node_b,
    input  logic [PRECISION+POINT-1:0]                          stamp_value,
    input  logic                                                stamp_last,
    output logic [SIZE-1:0][SIZE-1:0][PRECISION+POINT-1:0]      A,
    output logic [SIZE-1:0][PRECISION+POINT-1:0]                b,
    output logic                                                matrix_valid,
    output logic                                                sat,
    output logic                                                diag_err
);
    localparam int W  = PRECISION + POINT;
    localparam int NW = $clog2(SIZE+1);
    localparam logic [NW-1:0] GND_IDX  = NW'(SIZE);
    localparam logic [NW-1:0] LAST_IDX = NW'(SIZE-1);

    state_t                              state_q, state_d;
    logic                                kind_q, kind_d, last_q, last_d;
    logic [NW-1:0]                       na_q, na_d, nb_q, nb_d, chk_q, chk_d;
    logic [W-1:0]                        val_q, val_d;
    logic [SIZE-1:0][SIZE-1:0][W-1:0]    a_q, a_d;
    logic [SIZE-1:0][W-1:0]              bv_q, bv_d;
    logic                                sat_q, sat_d, derr_q, derr_d;

    logic          in_diag, in_off, a_gnd, b_gnd, live;
    logic [NW-1:0] ia, ib;
    logic [W-1:0]  x0, x1, x2, x3, r0, r1, r2, r3, diag_v;
    logic          o0, o1, o2, o3, we0, we1, we2, we3;

    // Ground indices are remapped to 0 only to keep reads in range; writes are masked.
    always_comb begin
        in_diag = (state_q == ST_APPLY_DIAG);
        in_off  = (state_q == ST_APPLY_OFF);
        a_gnd   = (na_q >= GND_IDX);
        b_gnd   = (nb_q >= GND_IDX);
        ia      = a_gnd ? '0 : na_q;
        ib      = b_gnd ? '0 : nb_q;
        x0      = in_diag ? a_q[ia][ia] : a_q[ia][ib];
        x1      = in_diag ? a_q[ib][ib] : a_q[ib][ia];
        x2      = bv_q[ia];
        x3      = bv_q[ib];
        live    = !start && (na_q != nb_q);
        we0 = live && (kind_q == KIND_COND) &&
              ((in_diag && !a_gnd) || (in_off && !a_gnd && !b_gnd));
        we1 = live && (kind_q == KIND_COND) &&
              ((in_diag && !b_gnd) || (in_off && !a_gnd && !b_gnd));
        we2 = live && (kind_q == KIND_CURR) && in_diag && !a_gnd;
        we3 = live && (kind_q == KIND_CURR) && in_off && !b_gnd;
        diag_v = a_q[chk_q][chk_q];
    end

    sat_addsub #(.W(W)) u_add0 (.x(x0), .y(val_q), .sub(in_off), .r(r0), .ovf(o0));
    sat_addsub #(.W(W)) u_add1 (.x(x1), .y(val_q), .sub(in_off), .r(r1), .ovf(o1));
    sat_addsub #(.W(W)) u_add2 (.x(x2), .y(val_q), .sub(1'b0),   .r(r2), .ovf(o2));
    sat_addsub #(.W(W)) u_add3 (.x(x3), .y(val_q), .sub(1'b1),   .r(r3), .ovf(o3));

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        last_d  = last_q;
        na_d    = na_q;
        nb_d    = nb_q;
        val_d   = val_q;
        chk_d   = chk_q;
        a_d     = a_q;
        bv_d    = bv_q;
        sat_d   = sat_q;
        derr_d  = derr_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_CLEAR: begin
                a_d     = '0;
                bv_d    = '0;
                sat_d   = 1'b0;
                derr_d  = 1'b0;
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (stamp_valid) begin
                    kind_d  = stamp_kind;
                    na_d    = node_a;
                    nb_d    = node_b;
                    val_d   = stamp_value;
                    last_d  = stamp_last;
                    state_d = ST_APPLY_DIAG;
                end
            end
            ST_APPLY_DIAG: state_d = ST_APPLY_OFF;
            ST_APPLY_OFF: begin
                chk_d   = '0;
                state_d = last_q ? ST_CHECK : ST_ACCEPT;
            end
            ST_CHECK: begin
                if (diag_v[W-1] || (diag_v == '0))
                    derr_d = 1'b1;
                chk_d   = chk_q + 1'b1;
                if (chk_q == LAST_IDX)
                    state_d = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        if (we0) begin
            if (in_diag) a_d[ia][ia] = r0;
            else         a_d[ia][ib] = r0;
        end
        if (we1) begin
            if (in_diag) a_d[ib][ib] = r1;
            else         a_d[ib][ia] = r1;
        end
        if (we2) bv_d[ia] = r2;
        if (we3) bv_d[ib] = r3;
        sat_d = sat_d | (we0 & o0) | (we1 & o1) | (we2 & o2) | (we3 & o3);

        // A start anywhere restarts assembly; a stamp offered alongside it is dropped.
        if (start)
            state_d = ST_CLEAR;
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= ST_IDLE;
            kind_q  <= 1'b0;
            last_q  <= 1'b0;
            na_q    <= '0;
            nb_q    <= '0;
            val_q   <= '0;
            chk_q   <= '0;
            a_q     <= '0;
            bv_q    <= '0;
            sat_q   <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            val_q   <= val_d;
            chk_q   <= chk_d;
            a_q     <= a_d;
            bv_q    <= bv_d;
            sat_q   <= sat_d;
            derr_q  <= derr_d;
        end
    end

    assign A            = a_q;
    assign b            = bv_q;
    assign stamp_ready  = (state_q == ST_ACCEPT);
    assign matrix_valid = (state_q == ST_DONE);
    assign sat          = sat_q;
    assign diag_err     = derr_q;
endmodule
